// File: rtl/axis_multi_slave_decoupler.sv
// Multi-channel AXI-Stream slave-side decoupler: per-channel passive/forced decouple
// with packet-boundary tracking, drain timeout and saturating drop counters.
module axis_multi_slave_decoupler #(
  parameter int unsigned NUM_CHANNELS          = 4,
  parameter int unsigned AXIS_BUS_WIDTH        = 64,
  parameter int unsigned AXIS_DEST_WIDTH       = 4,
  parameter int unsigned DISALLOW_BACKPRESSURE = 0,
  parameter int unsigned TIMEOUT_CYCLES        = 1024,
  parameter int unsigned DROP_CNT_WIDTH        = 16
) (
  input  logic                                      aclk,
  input  logic                                      aresetn,
  input  logic [NUM_CHANNELS*AXIS_BUS_WIDTH-1:0]    axis_s_tdata,
  input  logic [NUM_CHANNELS*AXIS_DEST_WIDTH-1:0]   axis_s_tdest,
  input  logic [NUM_CHANNELS*AXIS_BUS_WIDTH/8-1:0]  axis_s_tkeep,
  input  logic [NUM_CHANNELS-1:0]                   axis_s_tlast,
  input  logic [NUM_CHANNELS-1:0]                   axis_s_tvalid,
  output logic [NUM_CHANNELS-1:0]                   axis_s_tready,
  output logic [NUM_CHANNELS*AXIS_BUS_WIDTH-1:0]    axis_m_tdata,
  output logic [NUM_CHANNELS*AXIS_DEST_WIDTH-1:0]   axis_m_tdest,
  output logic [NUM_CHANNELS*AXIS_BUS_WIDTH/8-1:0]  axis_m_tkeep,
  output logic [NUM_CHANNELS-1:0]                   axis_m_tlast,
  output logic [NUM_CHANNELS-1:0]                   axis_m_tvalid,
  input  logic [NUM_CHANNELS-1:0]                   axis_m_tready,
  input  logic [NUM_CHANNELS-1:0]                   decouple,
  input  logic [NUM_CHANNELS-1:0]                   decouple_force,
  input  logic [NUM_CHANNELS-1:0]                   drop_cnt_clear,
  output logic [NUM_CHANNELS-1:0]                   decouple_done,
  output logic [NUM_CHANNELS-1:0]                   decoupled,
  output logic [NUM_CHANNELS-1:0]                   packet_dropped,
  output logic [NUM_CHANNELS-1:0]                   truncated,
  output logic [NUM_CHANNELS*DROP_CNT_WIDTH-1:0]    drop_count
);

  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam bit          NO_BP   = (DISALLOW_BACKPRESSURE != 0);

  typedef enum logic [1:0] {
    ST_COUPLED   = 2'd0,
    ST_DRAINING  = 2'd1,
    ST_DECOUPLED = 2'd2
  } state_e;

  // Payload is a pure wire copy; only the handshake is gated.
  assign axis_m_tdata = axis_s_tdata;
  assign axis_m_tdest = axis_s_tdest;
  assign axis_m_tkeep = axis_s_tkeep;
  assign axis_m_tlast = axis_s_tlast;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_e                    state_q, state_d;
    logic                      in_pkt_q, in_pkt_d;
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      dropped_q, dropped_d;
    logic                      trunc_q, trunc_d;
    logic                      s_ready;
    logic                      hs;
    logic                      hs_last;
    logic                      in_pkt_nxt;
    logic                      timeout_hit;
    logic                      drop_inc;

    assign s_ready     = NO_BP || (state_q == ST_DECOUPLED) || axis_m_tready[c];
    assign hs          = axis_s_tvalid[c] & s_ready;
    assign hs_last     = hs & axis_s_tlast[c];
    assign in_pkt_nxt  = hs ? ~axis_s_tlast[c] : in_pkt_q;
    assign timeout_hit = TO_EN && (state_q == ST_DRAINING) && !hs &&
                         (to_cnt_q == TO_W'(TO_LAST));
    assign drop_inc    = (state_q == ST_DECOUPLED) && hs_last;

    // Next-state and pulse generation
    always_comb begin
      state_d   = state_q;
      trunc_d   = 1'b0;
      dropped_d = 1'b0;
      in_pkt_d  = in_pkt_nxt;
      to_cnt_d  = '0;
      unique case (state_q)
        ST_COUPLED: begin
          if (decouple_force[c]) begin
            state_d = ST_DECOUPLED;
            trunc_d = in_pkt_nxt;
          end else if (decouple[c]) begin
            state_d = in_pkt_nxt ? ST_DRAINING : ST_DECOUPLED;
          end
        end
        ST_DRAINING: begin
          to_cnt_d = hs ? '0 : to_cnt_q + TO_W'(1);
          if (decouple_force[c]) begin
            state_d = ST_DECOUPLED;
            trunc_d = ~hs_last;
          end else if (hs_last) begin
            state_d = decouple[c] ? ST_DECOUPLED : ST_COUPLED;
          end else if (!decouple[c]) begin
            state_d = ST_COUPLED;
          end else if (timeout_hit) begin
            state_d = ST_DECOUPLED;
            trunc_d = 1'b1;
          end
        end
        ST_DECOUPLED: begin
          dropped_d = hs_last;
          // Stay until the packet currently being discarded has ended.
          if (!decouple[c] && !decouple_force[c] && !in_pkt_nxt) begin
            state_d = ST_COUPLED;
          end
        end
        default: state_d = ST_COUPLED;
      endcase
    end

    // Saturating drop counter; a clear coincident with a drop leaves one count.
    always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_cnt_clear[c]) begin
        drop_cnt_d = drop_inc ? DROP_CNT_WIDTH'(1) : '0;
      end else if (drop_inc && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        state_q    <= ST_COUPLED;
        in_pkt_q   <= 1'b0;
        to_cnt_q   <= '0;
        drop_cnt_q <= '0;
        dropped_q  <= 1'b0;
        trunc_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        in_pkt_q   <= in_pkt_d;
        to_cnt_q   <= to_cnt_d;
        drop_cnt_q <= drop_cnt_d;
        dropped_q  <= dropped_d;
        trunc_q    <= trunc_d;
      end
    end

    assign axis_m_tvalid[c] = axis_s_tvalid[c] & (state_q != ST_DECOUPLED);
    assign axis_s_tready[c] = s_ready;
    assign decoupled[c]     = (state_q == ST_DECOUPLED);
    assign decouple_done[c] = (decouple[c] | decouple_force[c]) & (state_q == ST_DECOUPLED);
    assign packet_dropped[c] = dropped_q;
    assign truncated[c]      = trunc_q;
    assign drop_count[c*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_cnt_q;
  end

endmodule
